// File: rtl/krms_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | krms_pkg : shared constants and state encoding for the scale-apply    |
// | stage.  Rev 1.0                                                        |
// +-----------------------------------------------------------------------+
package krms_pkg;

  localparam int K_MSB = 78;
  localparam int K_LSB = 69;

  localparam logic signed [7:0] INT8_MAX = 8'sd127;
  localparam logic signed [7:0] INT8_MIN = -8'sd128;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FILL       = 2'd1,
    ST_WAIT_SCALE = 2'd2,
    ST_DRAIN      = 2'd3
  } apply_state_e;

endpackage
`default_nettype wire

// File: rtl/krms_scale_apply_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | krms_scale_apply_if : input stream, scale strobe and normalized       |
// | output stream of the scale-apply stage.  Rev 1.0                      |
// +-----------------------------------------------------------------------+
interface krms_scale_apply_if #(
  parameter int BUS_NUM     = 8,
  parameter int SCALE_WIDTH = 24
);
  logic                     start;
  logic                     rc_cfg_vld;
  logic [83:0]              rc_cfg;
  logic [4:0]               cfg_out_shift;
  logic [BUS_NUM*8-1:0]     in_fixed_data;
  logic                     in_fixed_data_vld;
  logic [SCALE_WIDTH-1:0]   rc_scale;
  logic                     rc_scale_vld;
  logic [BUS_NUM*8-1:0]     out_data;
  logic                     out_data_vld;
  logic                     done;
  logic                     busy;
  logic                     ovf_err;

  modport master (
    output start, rc_cfg_vld, rc_cfg, cfg_out_shift, in_fixed_data,
           in_fixed_data_vld, rc_scale, rc_scale_vld,
    input  out_data, out_data_vld, done, busy, ovf_err
  );

  modport slave (
    input  start, rc_cfg_vld, rc_cfg, cfg_out_shift, in_fixed_data,
           in_fixed_data_vld, rc_scale, rc_scale_vld,
    output out_data, out_data_vld, done, busy, ovf_err
  );
endinterface
`default_nettype wire

// File: rtl/krms_apply_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | krms_apply_buf : simple dual-port vector buffer, one write port and   |
// | one synchronous read port, array not reset.  Rev 1.0                  |
// +-----------------------------------------------------------------------+
module krms_apply_buf #(
  parameter int DEPTH  = 128,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 7
) (
  input  wire logic              clk,
  input  wire logic              we_i,
  input  wire logic [ADDR_W-1:0] waddr_i,
  input  wire logic [WIDTH-1:0]  wdata_i,
  input  wire logic              re_i,
  input  wire logic [ADDR_W-1:0] raddr_i,
  output      logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/krms_scale_apply.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | krms_scale_apply : buffers a K-element int8 vector, waits for its     |
// | 1/rms scale, then replays it scaled, rounded and saturated.  Rev 1.0  |
// +-----------------------------------------------------------------------+
module krms_scale_apply
  import krms_pkg::*;
#(
  parameter int BUS_NUM        = 8,
  parameter int DATA_NUM_WIDTH = 10,
  parameter int SCALE_WIDTH    = 24,
  parameter int BUF_DEPTH      = 128
) (
  input wire logic           clk,
  input wire logic           rst_n,
  krms_scale_apply_if.slave  bus
);

  localparam int DW     = BUS_NUM * 8;
  localparam int PW     = 33;
  localparam int ADDR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [DATA_NUM_WIDTH-1:0] DEPTH_C = DATA_NUM_WIDTH'(BUF_DEPTH);

  apply_state_e state_q, state_d;

  logic [DATA_NUM_WIDTH-1:0] cfg_k_q, k_q, k_d, nbeat_q, nbeat_d, cfg_nbeat;
  logic [DATA_NUM_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_NUM_WIDTH-1:0] idx1_q, idx2_q;
  logic [4:0]                cfg_sh_q, sh_q, sh_d;
  logic [SCALE_WIDTH-1:0]    scale_q, scale_d;
  logic                      scale_rdy_q, scale_rdy_d, issued_q, issued_d;
  logic                      done_q, done_d, ovf_q, ovf_d;
  logic                      v1_q, v2_q, out_vld_q;
  logic                      buf_we, buf_re;
  logic [DW-1:0]             buf_rdata, res_d, out_data_q;
  logic [BUS_NUM*PW-1:0]     prod_d, prod_q;

  assign cfg_nbeat = DATA_NUM_WIDTH'((32'(cfg_k_q) + BUS_NUM - 1) / BUS_NUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_k_q  <= '0;
      cfg_sh_q <= '0;
    end else if (bus.rc_cfg_vld) begin
      cfg_k_q  <= DATA_NUM_WIDTH'(bus.rc_cfg[K_MSB:K_LSB]);
      cfg_sh_q <= bus.cfg_out_shift;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    sh_d        = sh_q;
    nbeat_d     = nbeat_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    scale_d     = scale_q;
    scale_rdy_d = scale_rdy_q;
    issued_d    = issued_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    buf_we      = 1'b0;
    buf_re      = 1'b0;

    // A strobe may land during FILL; it is held until the buffer is complete.
    if ((state_q == ST_FILL || state_q == ST_WAIT_SCALE) && bus.rc_scale_vld) begin
      scale_d     = bus.rc_scale;
      scale_rdy_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (cfg_k_q == '0) begin
            done_d = 1'b1;
          end else begin
            k_d         = cfg_k_q;
            sh_d        = cfg_sh_q;
            nbeat_d     = cfg_nbeat;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            scale_rdy_d = 1'b0;
            issued_d    = 1'b0;
            state_d     = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (bus.in_fixed_data_vld) begin
          if (wr_ptr_q == DEPTH_C) begin
            ovf_d = 1'b1;
          end else begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_d == nbeat_q) state_d = ST_WAIT_SCALE;
          end
        end
      end
      ST_WAIT_SCALE: begin
        if (scale_rdy_q || bus.rc_scale_vld) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!issued_q) begin
          buf_re   = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == nbeat_q - 1'b1) issued_d = 1'b1;
        end else if (!v1_q && !v2_q && out_vld_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      sh_q        <= '0;
      nbeat_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      scale_q     <= '0;
      scale_rdy_q <= 1'b0;
      issued_q    <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_vld_q   <= 1'b0;
      idx1_q      <= '0;
      idx2_q      <= '0;
      prod_q      <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      sh_q        <= sh_d;
      nbeat_q     <= nbeat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      scale_q     <= scale_d;
      scale_rdy_q <= scale_rdy_d;
      issued_q    <= issued_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      v1_q        <= buf_re;
      idx1_q      <= rd_ptr_q;
      v2_q        <= v1_q;
      idx2_q      <= idx1_q;
      prod_q      <= prod_d;
      out_vld_q   <= v2_q;
      out_data_q  <= v2_q ? res_d : '0;
    end
  end

  krms_apply_buf #(
    .DEPTH  (BUF_DEPTH),
    .WIDTH  (DW),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (bus.in_fixed_data),
    .re_i    (buf_re),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (buf_rdata)
  );

  for (genvar i = 0; i < BUS_NUM; i++) begin : g_lane
    logic signed [7:0]    din;
    logic signed [PW-1:0] prod;
    logic signed [PW:0]   bias, sum, shr;
    logic signed [7:0]    sat;

    assign din  = buf_rdata[i*8 +: 8];
    assign prod_d[i*PW +: PW] = din * $signed({1'b0, scale_q});
    assign prod = prod_q[i*PW +: PW];
    // One extra bit keeps the half-LSB bias from overflowing the product.
    assign bias = (sh_q == 5'd0) ? '0 : ((PW+1)'(1) <<< (sh_q - 5'd1));
    assign sum  = {prod[PW-1], prod} + bias;
    assign shr  = sum >>> sh_q;
    assign sat  = (shr > (PW+1)'(INT8_MAX)) ? INT8_MAX :
                  (shr < (PW+1)'(INT8_MIN)) ? INT8_MIN : shr[7:0];
    assign res_d[i*8 +: 8] = ((32'(idx2_q) * BUS_NUM + i) >= 32'(k_q)) ? 8'd0 : sat;
  end

  assign bus.out_data     = out_data_q;
  assign bus.out_data_vld = out_vld_q;
  assign bus.done         = done_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.ovf_err      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_krms_scale_apply.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_krms_scale_apply : randomized vectors against a plain-arithmetic   |
// | model of scale, round-half-up and int8 saturation.  Rev 1.0           |
// +-----------------------------------------------------------------------+
module tb_krms_scale_apply;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  krms_scale_apply_if #(.BUS_NUM(8), .SCALE_WIDTH(24)) bus ();
  krms_scale_apply_if #(.BUS_NUM(8), .SCALE_WIDTH(24)) sbus ();

  krms_scale_apply #(.BUS_NUM(8), .DATA_NUM_WIDTH(10), .SCALE_WIDTH(24), .BUF_DEPTH(128))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  krms_scale_apply #(.BUS_NUM(8), .DATA_NUM_WIDTH(10), .SCALE_WIDTH(24), .BUF_DEPTH(2))
    u_small (.clk(clk), .rst_n(rst_n), .bus(sbus));

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Element result straight from the arithmetic definition.
  function automatic logic [7:0] ref_lane(input int d, input longint scale, input int sh);
    longint p;
    p = longint'(d) * scale;
    if (sh > 0) p = p + (longint'(1) << (sh - 1));
    p = p >>> sh;
    if (p > 127)  p = 127;
    if (p < -128) p = -128;
    return p[7:0];
  endfunction

  logic [63:0] exp_q[$];
  logic [63:0] exp_beat;
  bit          prev_vld = 1'b0;
  bit          k0_mode  = 1'b0;
  int          done_seen = 0;
  int          first_vld_cyc = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (bus.out_data_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          exp_beat = exp_q.pop_front();
          chk("out_data", bus.out_data, exp_beat);
        end
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
      end
      if (!k0_mode) chk("done_timing", 64'(bus.done), 64'(prev_vld && !bus.out_data_vld));
      if (bus.done) done_seen++;
      prev_vld = bus.out_data_vld;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int k, input int sh);
    bus.rc_cfg         = 84'({$urandom(), $urandom(), $urandom()});
    bus.rc_cfg[78:69]  = 10'(k);
    bus.cfg_out_shift  = 5'(sh);
    bus.rc_cfg_vld     = 1'b1;
    tick();
    bus.rc_cfg_vld     = 1'b0;
  endtask

  // smode 0: strobe on first beat; 1: strobe 5 cycles after fill; 2: bogus
  // strobe on first beat overwritten by the real one on the last beat.
  task automatic run_vec(input int k, input int sh, input int scale, input int smode,
                         input bit cdata, input int cval, input bit busy_start, input bit abort);
    int nb, exp_first, last_cyc, s_cyc, n, d0;
    int dv[];
    logic [63:0] e;
    nb = (k + 7) / 8;
    dv = new[nb * 8];
    foreach (dv[i]) dv[i] = cdata ? cval : int'($urandom_range(0, 255)) - 128;
    for (int b = 0; b < nb; b++) begin
      e = '0;
      for (int l = 0; l < 8; l++)
        if (b * 8 + l < k) e[l*8 +: 8] = ref_lane(dv[b*8+l], longint'(scale), sh);
      exp_q.push_back(e);
    end
    set_cfg(k, sh);
    first_vld_cyc = -1;
    d0 = done_seen;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    last_cyc = cyc;
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 2)) tick();
      for (int l = 0; l < 8; l++) bus.in_fixed_data[l*8 +: 8] = dv[b*8+l][7:0];
      bus.in_fixed_data_vld = 1'b1;
      if (b == 0 && smode != 1) begin
        bus.rc_scale     = (smode == 2) ? ~24'(scale) : 24'(scale);
        bus.rc_scale_vld = 1'b1;
      end
      if (b == nb - 1 && smode == 2) begin
        bus.rc_scale     = 24'(scale);
        bus.rc_scale_vld = 1'b1;
      end
      if (b == 0 && busy_start) begin
        bus.start         = 1'b1;
        bus.rc_cfg_vld    = 1'b1;
        bus.rc_cfg[78:69] = 10'(k + 3);
        bus.cfg_out_shift = 5'(sh + 1);
      end
      last_cyc = cyc;
      tick();
      bus.in_fixed_data_vld = 1'b0;
      bus.rc_scale_vld      = 1'b0;
      bus.start             = 1'b0;
      bus.rc_cfg_vld        = 1'b0;
    end
    exp_first = last_cyc + 5;
    if (smode == 1) begin
      repeat (5) tick();
      bus.rc_scale     = 24'(scale);
      bus.rc_scale_vld = 1'b1;
      s_cyc = cyc;
      tick();
      bus.rc_scale_vld = 1'b0;
      exp_first = s_cyc + 4;
    end
    n = 0;
    if (abort) begin
      while (first_vld_cyc < 0 && n < 300) begin tick(); n++; end
      chk("abort_reached_drain", 64'(first_vld_cyc >= 0), 64'd1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_out_data", bus.out_data, 64'd0);
      chk("rst_out_vld", 64'(bus.out_data_vld), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      exp_q.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      return;
    end
    while (done_seen == d0 && n < 600) begin tick(); n++; end
    chk("done_arrived", 64'(done_seen > d0), 64'd1);
    chk("beats_left", 64'(exp_q.size()), 64'd0);
    chk("first_beat_cycle", 64'(first_vld_cyc), 64'(exp_first));
    chk("idle_after_done", 64'(bus.busy), 64'd0);
    exp_q.delete();
    // A beat while idle must not be buffered or produce output.
    bus.in_fixed_data     = {$urandom(), $urandom()};
    bus.in_fixed_data_vld = 1'b1;
    tick();
    bus.in_fixed_data_vld = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    bus.start = 0; bus.rc_cfg_vld = 0; bus.rc_cfg = '0; bus.cfg_out_shift = '0;
    bus.in_fixed_data = '0; bus.in_fixed_data_vld = 0; bus.rc_scale = '0; bus.rc_scale_vld = 0;
    sbus.start = 0; sbus.rc_cfg_vld = 0; sbus.rc_cfg = '0; sbus.cfg_out_shift = '0;
    sbus.in_fixed_data = '0; sbus.in_fixed_data_vld = 0; sbus.rc_scale = '0; sbus.rc_scale_vld = 0;

    repeat (3) @(negedge clk);
    chk("reset_out_data", bus.out_data, 64'd0);
    chk("reset_out_vld", 64'(bus.out_data_vld), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_ovf", 64'(bus.ovf_err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    chk("model_unity", 64'(ref_lane(10, 64'h10000, 16)), 64'd10);
    chk("model_sat_hi", 64'(ref_lane(127, 64'h20000, 16)), 64'd127);
    chk("model_sat_lo", 64'(ref_lane(-128, 64'h20000, 16)), 64'h80);
    chk("model_round_pos", 64'(ref_lane(3, 64'h8000, 16)), 64'd2);
    chk("model_round_neg", 64'(ref_lane(-3, 64'h8000, 16)), 64'hFF);

    run_vec(16, 16, 'h010000, 0, 1, 10, 0, 0);
    run_vec(16, 16, 'h020000, 0, 1, 127, 0, 0);
    run_vec(16, 16, 'h020000, 0, 1, -128, 0, 0);
    run_vec(8, 16, 'h008000, 0, 1, 3, 0, 0);
    run_vec(8, 16, 'h008000, 0, 1, -3, 0, 0);
    run_vec(12, 14, 'h00a3c1, 0, 0, 0, 0, 0);
    run_vec(40, 16, 'h013579, 0, 1, 77, 0, 0);
    run_vec(40, 16, 'h013579, 1, 1, 77, 0, 0);
    run_vec(24, 12, 'h003210, 2, 0, 0, 1, 0);

    k0_mode = 1'b1;
    set_cfg(0, 4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    chk("k0_done", 64'(bus.done), 64'd1);
    chk("k0_busy", 64'(bus.busy), 64'd0);
    tick();
    @(negedge clk);
    chk("k0_done_clear", 64'(bus.done), 64'd0);
    tick();
    k0_mode = 1'b0;

    for (int it = 0; it < 10; it++)
      run_vec((it == 0) ? 1023 : int'($urandom_range(1, 100)), int'($urandom_range(0, 24)),
              int'($urandom_range(0, 24'hFFFFFF)), int'($urandom_range(0, 2)), 0, 0, 0, 0);

    sbus.rc_cfg[78:69] = 10'd24;
    sbus.rc_cfg_vld = 1'b1;
    tick();
    sbus.rc_cfg_vld = 1'b0;
    sbus.start = 1'b1;
    tick();
    sbus.start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      if (b == 2) chk("ovf_before_third", 64'(sbus.ovf_err), 64'd0);
      sbus.in_fixed_data = {$urandom(), $urandom()};
      sbus.in_fixed_data_vld = 1'b1;
      tick();
      sbus.in_fixed_data_vld = 1'b0;
    end
    @(negedge clk);
    chk("ovf_set", 64'(sbus.ovf_err), 64'd1);
    chk("ovf_still_busy", 64'(sbus.busy), 64'd1);
    tick();

    run_vec(64, 16, 'h00c000, 0, 0, 0, 0, 1);
    chk("small_ovf_cleared", 64'(sbus.ovf_err), 64'd0);
    run_vec(8, 16, 'h005a5a, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
